// File: rtl/nibbler_input_port.sv
// nibbler_input_port: synchronised, debounced 4-bit pushbutton port feeding the uP core.
// Latency: buttons_raw to level/event is DEBOUNCE_CYCLES+2 rising edges (2 sync + debounce run).
// Backpressure: none; press events are sticky until a rd_strobe edge clears them (set wins).
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low; clears all state
//   buttons_raw  raw asynchronous bouncing buttons (1 = pressed)
//   rd_strobe    core reads the port this cycle; clears sticky press events at the edge
//   pushbuttons  value seen by the core: sticky events or debounced levels (see macro)
//   level        debounced stable level per button
//   any_event    OR of the four sticky press-event flags
//
// Build option: define INPUT_PORT_EDGE_LATCH_EN to present sticky press events on
// pushbuttons; otherwise pushbuttons carries the debounced level. The event flags
// and any_event behave identically in both builds.
//
// DEBOUNCE_CYCLES must lie in 1..2**CNT_W so that DEBOUNCE_CYCLES-1 fits the counter.

module nibbler_input_port #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttons_raw,
  input  logic       rd_strobe,
  output logic [3:0] pushbuttons,
  output logic [3:0] level,
  output logic       any_event
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchroniser per bit.
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Debounce state per bit.
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0][CNT_W-1:0] cnt_d;
  logic [3:0]            stable_q;
  logic [3:0]            stable_d;

  // Sticky press events.
  logic [3:0] event_q;
  logic [3:0] event_d;
  logic [3:0] press;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons_raw;
      sync2_q <= sync1_q;
    end
  end

  // Counter only advances while the synchronised value disagrees with the
  // stable value; any agreement restarts the run, which is what rejects glitches.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Only a 0->1 flip of the stable level is a press; a new press on the read
  // edge overrides the clear so it is never lost.
  always_comb begin
    press   = stable_d & ~stable_q;
    event_d = press | (event_q & ~{4{rd_strobe}});
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      stable_q <= '0;
      event_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      event_q  <= event_d;
    end
  end

  assign level     = stable_q;
  assign any_event = |event_q;

`ifdef INPUT_PORT_EDGE_LATCH_EN
  assign pushbuttons = event_q;
`else
  assign pushbuttons = stable_q;
`endif

endmodule
